// File: rtl/dram_model_if.sv
// Request/response bus between the core's memory clients and the main-memory model.
// A request transfers on a rising edge where req_valid and req_ready are both high;
// resp_valid is a one-cycle pulse with no back-pressure, and resp_* hold their values otherwise.
interface dram_model_if #(
  parameter int ADDR_W = 21,
  parameter int TAG_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic [TAG_W-1:0]  req_tag;
  logic              resp_valid;
  logic              resp_write;
  logic [63:0]       resp_data;
  logic [TAG_W-1:0]  resp_tag;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_tag,
    input  req_ready, resp_valid, resp_write, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_tag,
    output req_ready, resp_valid, resp_write, resp_data, resp_tag
  );
endinterface

// File: rtl/dram_model.sv
// Main-memory model: one outstanding 64-bit read/write with fixed latency,
// plus a byte-wide preload port that may write in any state.
module dram_model #(
  parameter int ADDR_W        = 21,
  parameter int MEM_BYTES     = 65536,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2,
  parameter int TAG_W         = 4
) (
  input  logic              clk,
  input  logic              reset,
  dram_model_if.slave       bus,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [7:0]        init_data,
  output logic [1:0]        dbg_state
);
  localparam int IDX_W = $clog2(MEM_BYTES);
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESPOND = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic [63:0]      wdata_q, wdata_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [63:0]      hold_data_q, hold_data_d;
  logic [TAG_W-1:0] hold_tag_q, hold_tag_d;
  logic             hold_write_q, hold_write_d;

  logic [7:0]       mem_q [MEM_BYTES];

  logic             req_ready;
  logic             resp_valid;
  logic             accept;
  logic             short_lat;
  logic [CNT_W-1:0] busy_cnt;
  logic [63:0]      rd_data;
  logic             unused_addr_bits;

  // Addresses wrap modulo MEM_BYTES, so the high address bits carry no information.
  assign unused_addr_bits = ^{bus.req_addr[ADDR_W-1:IDX_W], init_addr[ADDR_W-1:IDX_W]};

  // BUSY lasts latency-1 cycles; a latency of 1 goes straight to RESPOND.
  always_comb begin
    short_lat = 1'b0;
    busy_cnt  = '0;
    if (bus.req_write) begin
      short_lat = (WRITE_LATENCY < 2);
      busy_cnt  = (WRITE_LATENCY < 2) ? '0 : CNT_W'(WRITE_LATENCY - 2);
    end else begin
      short_lat = (READ_LATENCY < 2);
      busy_cnt  = (READ_LATENCY < 2) ? '0 : CNT_W'(READ_LATENCY - 2);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, RESPOND: begin
        if (accept) begin
          state_d = short_lat ? RESPOND : BUSY;
          cnt_d   = busy_cnt;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = RESPOND;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = !reset && (state_q != BUSY);
    resp_valid = !reset && (state_q == RESPOND);
    accept     = bus.req_valid && req_ready;
    rd_data    = '0;
    for (int i = 0; i < 8; i++) rd_data[8*i +: 8] = mem_q[addr_q + IDX_W'(i)];
    bus.req_ready  = req_ready;
    bus.resp_valid = resp_valid;
    bus.resp_write = resp_valid ? write_q : hold_write_q;
    bus.resp_tag   = resp_valid ? tag_q : hold_tag_q;
    bus.resp_data  = resp_valid ? (write_q ? 64'd0 : rd_data) : hold_data_q;
    dbg_state      = state_q;
  end

  always_comb begin
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    tag_d        = tag_q;
    hold_data_d  = hold_data_q;
    hold_tag_d   = hold_tag_q;
    hold_write_d = hold_write_q;
    if (accept) begin
      write_d = bus.req_write;
      addr_d  = bus.req_addr[IDX_W-1:0];
      wdata_d = bus.req_wdata;
      tag_d   = bus.req_tag;
    end
    if (resp_valid) begin
      hold_data_d  = bus.resp_data;
      hold_tag_d   = bus.resp_tag;
      hold_write_d = bus.resp_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      tag_q        <= '0;
      hold_data_q  <= '0;
      hold_tag_q   <= '0;
      hold_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      tag_q        <= tag_d;
      hold_data_q  <= hold_data_d;
      hold_tag_q   <= hold_tag_d;
      hold_write_q <= hold_write_d;
    end
  end

  // Storage is never cleared; the preload write comes last so it wins a byte collision.
  always_ff @(posedge clk) begin
    if (resp_valid && write_q) begin
      for (int i = 0; i < 8; i++) mem_q[addr_q + IDX_W'(i)] <= wdata_q[8*i +: 8];
    end
    if (init_we) mem_q[init_addr[IDX_W-1:0]] <= init_data;
  end
endmodule

// File: tb/tb_dram_model.sv
// Directed bench for dram_model: expectations go into a scoreboard queue when a
// request is accepted and are checked when the response pulse appears.
module tb_dram_model;
  localparam int ADDR_W    = 21;
  localparam int MEM_BYTES = 65536;
  localparam int RL        = 4;
  localparam int WL        = 2;
  localparam int TAG_W     = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [7:0]        init_data;
  logic [1:0]        dbg_state;

  dram_model_if #(.ADDR_W(ADDR_W), .TAG_W(TAG_W)) bus ();

  dram_model #(
    .ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .READ_LATENCY(RL),
    .WRITE_LATENCY(WL), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  logic [63:0]      exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];
  logic             exp_write_q[$];
  int               exp_cyc_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
  endtask

  // scoreboard: every response pulse must match the oldest expectation
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      chk("resp_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        chk("resp_cycle", 64'(exp_cyc_q.pop_front()) == 64'(cyc) ? 64'd1 : 64'(cyc), 64'd1);
        chk("resp_data", bus.resp_data, exp_q.pop_front());
        chk("resp_tag", 64'(bus.resp_tag), 64'(exp_tag_q.pop_front()));
        chk("resp_write", 64'(bus.resp_write), 64'(exp_write_q.pop_front()));
      end
    end
  end

  // driver tasks: all start and end just after a falling edge
  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    @(negedge clk);
    init_we = 1'b0;
  endtask

  task automatic send(input logic w, input logic [ADDR_W-1:0] a, input logic [63:0] d,
                      input logic [TAG_W-1:0] t, input logic [63:0] exp, input bit track,
                      output int acc);
    int waited = 0;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_addr = a;
    bus.req_wdata = d; bus.req_tag = t;
    while (bus.req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    acc = cyc;
    chk("req_accept", 64'(bus.req_ready), 64'd1);
    if (track) begin
      exp_q.push_back(exp);
      exp_tag_q.push_back(t);
      exp_write_q.push_back(w);
      exp_cyc_q.push_back(acc + (w ? WL : RL));
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_w, acc_r;
    logic [ADDR_W-1:0] ra;
    logic [63:0]       rd;
    reset = 1'b1; init_we = 1'b0; init_addr = '0; init_data = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_tag = '0;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", 64'(bus.req_ready), 64'd0);
    chk("valid_in_reset", 64'(bus.resp_valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_ready", 64'(bus.req_ready), 64'd1);
    chk("reset_valid", 64'(bus.resp_valid), 64'd0);
    chk("reset_data", bus.resp_data, 64'd0);
    chk("reset_write", 64'(bus.resp_write), 64'd0);
    chk("reset_tag", 64'(bus.resp_tag), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);

    // preload then aligned read
    for (int i = 0; i < 8; i++) preload(ADDR_W'(32'h100 + i), 8'((i + 1) * 8'h11));
    send(1'b0, 21'h100, 64'd0, 4'd3, 64'h8877665544332211, 1'b1, acc_r);
    drain();

    // write, then read accepted in the ack cycle
    send(1'b1, 21'h200, 64'hDEADBEEFCAFEF00D, 4'd5, 64'd0, 1'b1, acc_w);
    send(1'b0, 21'h200, 64'd0, 4'd6, 64'hDEADBEEFCAFEF00D, 1'b1, acc_r);
    chk("b2b_accept_cycle", 64'(acc_r - acc_w), 64'(WL));
    drain();
    chk("hold_data", bus.resp_data, 64'hDEADBEEFCAFEF00D);
    chk("hold_tag", 64'(bus.resp_tag), 64'd6);

    // unaligned read wrapping past the top, and an alias above MEM_BYTES
    preload(ADDR_W'(MEM_BYTES - 1), 8'hAA);
    preload(21'h0, 8'hBB);
    for (int i = 1; i < 7; i++) preload(ADDR_W'(i), 8'(i));
    send(1'b0, ADDR_W'(MEM_BYTES - 1), 64'd0, 4'd4, 64'h060504030201BBAA, 1'b1, acc_r);
    drain();
    send(1'b0, ADDR_W'(MEM_BYTES + 32'h100), 64'd0, 4'd8, 64'h8877665544332211, 1'b1, acc_r);
    drain();

    // request presented while busy is ignored
    send(1'b0, 21'h100, 64'd0, 4'd7, 64'h8877665544332211, 1'b1, acc_r);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 21'h104;
    bus.req_wdata = '1; bus.req_tag = 4'd9;
    chk("busy_ready_0", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    chk("busy_ready_1", 64'(bus.req_ready), 64'd0);
    bus.req_valid = 1'b0;
    drain();
    send(1'b0, 21'h100, 64'd0, 4'd10, 64'h8877665544332211, 1'b1, acc_r);
    drain();

    // preload collides with a committing write and wins
    send(1'b1, 21'h400, 64'h1111111111111111, 4'd11, 64'd0, 1'b1, acc_w);
    @(negedge clk);
    preload(21'h403, 8'h99);
    send(1'b0, 21'h400, 64'd0, 4'd12, 64'h1111111199111111, 1'b1, acc_r);
    drain();

    // reset during a pending write drops it
    for (int i = 0; i < 8; i++) preload(ADDR_W'(32'h300 + i), 8'h00);
    send(1'b1, 21'h300, 64'h123456789ABCDEF0, 4'd2, 64'd0, 1'b0, acc_w);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_ack_after_reset", 64'(bus.resp_valid), 64'd0);
    end
    send(1'b0, 21'h300, 64'd0, 4'd13, 64'd0, 1'b1, acc_r);
    drain();

    // random write/readback pairs
    for (int k = 0; k < 6; k++) begin
      ra = ADDR_W'(32'h1000 + $urandom_range(0, 32'hFF8));
      rd = {$urandom, $urandom};
      send(1'b1, ra, rd, TAG_W'(k), 64'd0, 1'b1, acc_w);
      send(1'b0, ra, 64'd0, TAG_W'(k + 8), rd, 1'b1, acc_r);
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dram_model.md
# dram_model

Behavioural-but-synthesizable main-memory model that serves the core's memory bus. It sits behind the bus shared by the fetch stage and the vector memory controller. It accepts one 64-bit read or write request at a time, answers after a fixed latency, and provides a byte-wide preload port used to load the code and data segments before execution.

## Interface
Parameters:
- ADDR_W, 21: byte-address width (phys_memory_address_t).
- MEM_BYTES, 65536: storage size in bytes, power of two; addresses are taken modulo MEM_BYTES.
- READ_LATENCY, 4: cycles from request acceptance to read response, ≥2.
- WRITE_LATENCY, 2: cycles from request acceptance to write commit/ack, ≥1.
- TAG_W, 4: requester tag width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  model can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address of first byte.
- req_wdata  in  64  write data, little-endian (byte 0 = bits 7:0 at req_addr).
- req_tag  in  TAG_W  requester id, echoed in response.
- resp_valid  out  1  one-cycle response pulse (read data or write ack).
- resp_write  out  1  response belongs to a write.
- resp_data  out  64  read data; 0 for write acks.
- resp_tag  out  TAG_W  tag of the completed request.
- init_we  in  1  preload byte strobe.
- init_addr  in  ADDR_W  preload byte address.
- init_data  in  8  preload byte.

## Operation
- Storage: MEM_BYTES × 8-bit array; contents not cleared by reset and undefined until written.
- States: IDLE, BUSY, RESPOND.
  - IDLE: req_ready=1. req_valid=1 latches write, addr, wdata, tag, loads counter, and moves to BUSY.
  - BUSY: req_ready=0. Counter decrements. Moves to RESPOND when the total latency (READ_LATENCY or WRITE_LATENCY) elapses.
  - RESPOND: resp_valid=1 for one cycle. req_ready=1 in this state, so a new request can be accepted the same cycle; that acceptance goes to BUSY, otherwise the state returns to IDLE.
- Read: resp_data = bytes addr..addr+7 (mod MEM_BYTES), little-endian, sampled at the response cycle. Unaligned addresses are legal and wrap past the top of memory.
- Write: all 8 bytes commit at the clock edge ending the RESPOND cycle (ack cycle). A read issued afterwards sees the new data.
- Preload: init_we writes init_data to init_addr at the edge, in any state. If it hits a byte being written by a committing bus write in the same cycle, preload wins.
- A single outstanding request; no queuing. req_* inputs are ignored while req_ready=0.
- resp_data, resp_tag and resp_write hold their last values when resp_valid=0. resp_write is 0 after reset.

## Timing
- Reset values: state IDLE, req_ready 0 during the reset cycle and 1 from the first cycle after, resp_valid 0, resp_write 0, resp_data 0, resp_tag 0.
- Request accepted at edge T (req_valid & req_ready).
  - Read: resp_valid is high in cycle T+READ_LATENCY.
  - Write: resp_valid (ack) is high in cycle T+WRITE_LATENCY.
- Back-to-back: next request is accepted in the response cycle. Sustained throughput is one request per LATENCY cycles.
- Reset mid-operation: pending request is dropped, no response. An uncommitted write is not performed.
- Preload latency: 1 cycle; a read accepted the cycle after init_we sees the byte.

## Test plan
- Reset then idle -> req_ready=1, resp_valid=0, resp_data=0 on the cycle after reset deasserts.
- Preload bytes 0x11..0x88 at 0x100..0x107, read 0x100 tag 3 at T -> resp_valid only at T+4, resp_data=0x8877665544332211, resp_tag=3, resp_write=0.
- Write 0xDEADBEEFCAFEF00D to 0x200 at T -> ack at T+2 with resp_write=1 and resp_data=0. Read 0x200 accepted in the ack cycle -> returns 0xDEADBEEFCAFEF00D four cycles later.
- Unaligned/wrap: preload byte at MEM_BYTES-1 = 0xAA and address 0 = 0xBB, read MEM_BYTES-1 -> resp_data[15:0]=0xBBAA.
- Request while busy: assert req_valid with a different address during BUSY -> ignored (req_ready=0), and the original response is unchanged.
- Reset asserted at T+1 of a write to 0x300 holding 0x0 -> no ack. A later read of 0x300 returns 0x0.
